ram_bist: RTL

//  Self-contained memory test initiator for cpu_ram's data port; it is the requester side of the d_* handshake.
//  On start it writes an LCG pattern to every word, then reads each word back and compares it.
//  It then repeats both passes with the inverted pattern and reports pass/fail plus the first failing word.

---
 rtl/ram_bist.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ram_bist.sv
// Memory self-test initiator for the cpu_ram data port.
// It runs a write/read pass with an LCG pattern, then a second write/read pass with the inverted pattern.
module ram_bist #(
    parameter int          SIZE    = 13,
    parameter logic [31:0] SEED    = 32'd12345,
    parameter int          TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [15:0]     err_count,
    output logic [SIZE+1:0] fail_addr,
    output logic [31:0]     fail_data,
    output logic [31:0]     fail_expect,
    output logic            d_req,
    output logic [SIZE+1:0] d_addr,
    output logic            d_we,
    output logic [3:0]      d_be,
    output logic [31:0]     d_wdata,
    input  logic [31:0]     d_rdata,
    input  logic            d_valid,
    output logic [2:0]      dbg_state
);
    // Handshake: d_req is a one-cycle pulse. d_addr, d_we, d_be and d_wdata stay stable
    // from the d_req cycle until d_valid. d_valid counts only in WR_WAIT and RD_WAIT.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TCNT_MAX  = TW'(TIMEOUT - 1);
    localparam logic [SIZE+1:0] LAST_ADDR = {{SIZE{1'b1}}, 2'b00};
    localparam logic [SIZE+1:0] ADDR_STEP = (SIZE+2)'(4);

    state_t          state;
    logic [SIZE+1:0] addr;
    logic [31:0]     lcg;
    logic            round;
    logic [TW-1:0]   tcnt;

    logic [31:0] pattern;
    logic        mismatch;
    logic        is_last;
    logic [15:0] err_next;

    function automatic logic [31:0] lcg_step(input logic [31:0] r);
        return r * 32'd1664525 + 32'd1013904223;
    endfunction

    // lcg always holds the value for the word at addr; round 1 uses the inverted value.
    assign pattern   = round ? ~lcg : lcg;
    assign mismatch  = (d_rdata != pattern);
    assign is_last   = (addr == LAST_ADDR);
    assign err_next  = (mismatch && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            err_count   <= 16'd0;
            fail_addr   <= '0;
            fail_data   <= 32'd0;
            fail_expect <= 32'd0;
            d_req       <= 1'b0;
            d_addr      <= '0;
            d_we        <= 1'b0;
            d_be        <= 4'b0000;
            d_wdata     <= 32'd0;
            addr        <= '0;
            lcg         <= 32'd0;
            round       <= 1'b0;
            tcnt        <= '0;
        end else begin
            d_req <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= WR_REQ;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        err_count   <= 16'd0;
                        fail_addr   <= '0;
                        fail_data   <= 32'd0;
                        fail_expect <= 32'd0;
                        round       <= 1'b0;
                        addr        <= '0;
                        lcg         <= lcg_step(SEED);
                    end
                end
                WR_REQ: begin
                    d_req   <= 1'b1;
                    d_addr  <= addr;
                    d_we    <= 1'b1;
                    d_be    <= 4'b1111;
                    d_wdata <= pattern;
                    tcnt    <= '0;
                    state   <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (d_valid) begin
                        if (is_last) begin
                            state <= RD_REQ;
                            addr  <= '0;
                            lcg   <= lcg_step(SEED);
                        end else begin
                            state <= WR_REQ;
                            addr  <= addr + ADDR_STEP;
                            lcg   <= lcg_step(lcg);
                        end
                    end else if (tcnt == TCNT_MAX) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RD_REQ: begin
                    d_req  <= 1'b1;
                    d_addr <= addr;
                    d_we   <= 1'b0;
                    d_be   <= 4'b0000;
                    tcnt   <= '0;
                    state  <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (d_valid) begin
                        err_count <= err_next;
                        // err_count is still zero only before the first mismatch of the run.
                        if (mismatch && err_count == 16'd0) begin
                            fail_addr   <= addr;
                            fail_data   <= d_rdata;
                            fail_expect <= pattern;
                        end
                        if (is_last) begin
                            if (!round) begin
                                state <= WR_REQ;
                                round <= 1'b1;
                                addr  <= '0;
                                lcg   <= lcg_step(SEED);
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (err_next == 16'd0);
                            end
                        end else begin
                            state <= RD_REQ;
                            addr  <= addr + ADDR_STEP;
                            lcg   <= lcg_step(lcg);
                        end
                    end else if (tcnt == TCNT_MAX) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
